// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg: Y86 icodes, status codes, sequencer state encodings
// and icode class helpers shared by the sequencer files.
package stage_sequencer_pkg;
   localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, IRRMOVQ = 4'h2, IIRMOVQ = 4'h3,
                          IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ = 4'h6, IJXX = 4'h7,
                          ICALL = 4'h8, IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB;
   typedef enum logic [3:0] {
      STAT_AOK = 4'd1,
      STAT_HLT = 4'd2,
      STAT_ADR = 4'd3,
      STAT_INS = 4'd4
   } stat_t;
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_MEMORY    = 3'd4,
      S_WRITEBACK = 3'd5,
      S_PC_UPDATE = 3'd6,
      S_HALT      = 3'd7
   } state_t;
   function automatic logic is_mem(input logic [3:0] ic);
      return ic inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
   endfunction
   function automatic logic is_write(input logic [3:0] ic);
      return ic inside {IRMMOVQ, ICALL, IPUSHQ};
   endfunction
   function automatic logic writes_reg(input logic [3:0] ic);
      return ic inside {IRRMOVQ, IIRMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ};
   endfunction
endpackage

// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: control/status bundle between sequencer (master) and datapath/memories (slave).
// SEQ_PERF_CNT_EN adds the cycle_cnt/retired_cnt performance counters.
interface stage_sequencer_if;
   logic       start, instr_valid, imem_error, dmem_error, imem_ack, dmem_ack;
   logic [3:0] icode;
   logic       imem_req, dmem_req, dmem_write;
   logic       f_en, e_en, m_en, wb_en, pc_en;
   logic [2:0] stage;
   logic [3:0] stat;
   logic       halted;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cycle_cnt, retired_cnt;
   modport master (input start, icode, instr_valid, imem_error, dmem_error, imem_ack, dmem_ack,
                   output imem_req, dmem_req, dmem_write, f_en, e_en, m_en, wb_en, pc_en,
                   stage, stat, halted, cycle_cnt, retired_cnt);
   modport slave (output start, icode, instr_valid, imem_error, dmem_error, imem_ack, dmem_ack,
                  input imem_req, dmem_req, dmem_write, f_en, e_en, m_en, wb_en, pc_en,
                  stage, stat, halted, cycle_cnt, retired_cnt);
`else
   modport master (input start, icode, instr_valid, imem_error, dmem_error, imem_ack, dmem_ack,
                   output imem_req, dmem_req, dmem_write, f_en, e_en, m_en, wb_en, pc_en,
                   stage, stat, halted);
   modport slave (output start, icode, instr_valid, imem_error, dmem_error, imem_ack, dmem_ack,
                  input imem_req, dmem_req, dmem_write, f_en, e_en, m_en, wb_en, pc_en,
                  stage, stat, halted);
`endif
endinterface

// File: rtl/stage_sequencer_mem_watchdog.sv
// mem_watchdog: counts consecutive run cycles; expired flags the LIMIT-th one.
module mem_watchdog #(
   parameter int LIMIT = 15
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic run,
   output logic expired
);
   localparam int W = $clog2(LIMIT + 1);
   logic [W-1:0] cnt_q, cnt_d;
   assign expired = run && cnt_q == W'(LIMIT - 1);
   assign cnt_d = clr ? '0 : (run && !expired) ? cnt_q + W'(1) : cnt_q;
   always_ff @(posedge CLK or posedge RST)
      if (RST) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle Y86 stage FSM with memory handshakes, fault status and dmem timeout.
// Define SEQ_PERF_CNT_EN to add cycle/retired performance counters.
module stage_sequencer
   import stage_sequencer_pkg::*;
#(
   parameter int DMEM_TIMEOUT = 15
) (
   input logic CLK,
   input logic RST,
   stage_sequencer_if.master bus
);
   state_t state_q, state_d;
   stat_t  stat_q, stat_d;
   logic   expired;
   mem_watchdog #(.LIMIT(DMEM_TIMEOUT)) u_wd (
      .CLK     (CLK),
      .RST     (RST),
      .clr     (state_q != S_MEMORY),
      .run     (state_q == S_MEMORY),
      .expired (expired)
   );
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state_q <= S_IDLE;
         stat_q  <= STAT_AOK;
      end else begin
         state_q <= state_d;
         stat_q  <= stat_d;
      end
   always_comb begin
      state_d = state_q;
      stat_d  = stat_q;
      case (state_q)
         S_IDLE:      state_d = bus.start ? S_FETCH : S_IDLE;
         S_FETCH:
            if (bus.imem_ack) begin
               state_d = (bus.imem_error || !bus.instr_valid) ? S_HALT : S_DECODE;
               stat_d  = bus.imem_error ? STAT_ADR : !bus.instr_valid ? STAT_INS : STAT_AOK;
            end
         S_DECODE: begin
            state_d = bus.icode == IHALT ? S_HALT : S_EXECUTE;
            stat_d  = bus.icode == IHALT ? STAT_HLT : STAT_AOK;
         end
         S_EXECUTE:   state_d = is_mem(bus.icode) ? S_MEMORY : S_WRITEBACK;
         // An ack in the limit cycle beats the watchdog.
         S_MEMORY:
            if (bus.dmem_ack || expired) begin
               state_d = (bus.dmem_ack && !bus.dmem_error) ? S_WRITEBACK : S_HALT;
               stat_d  = (bus.dmem_ack && !bus.dmem_error) ? STAT_AOK : STAT_ADR;
            end
         S_WRITEBACK: state_d = S_PC_UPDATE;
         S_PC_UPDATE: state_d = S_FETCH;
         default:     state_d = S_HALT;
      endcase
   end
   assign bus.imem_req   = state_q == S_FETCH;
   assign bus.f_en       = state_q == S_FETCH && bus.imem_ack && !bus.imem_error && bus.instr_valid;
   assign bus.e_en       = state_q == S_EXECUTE;
   assign bus.dmem_req   = state_q == S_MEMORY;
   assign bus.dmem_write = state_q == S_MEMORY && is_write(bus.icode);
   assign bus.m_en       = state_q == S_MEMORY && bus.dmem_ack && !bus.dmem_error;
   assign bus.wb_en      = state_q == S_WRITEBACK && writes_reg(bus.icode);
   assign bus.pc_en      = state_q == S_PC_UPDATE;
   assign bus.stage      = state_q;
   assign bus.stat       = stat_q;
   assign bus.halted     = state_q == S_HALT;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cycle_q, cycle_d, retired_q, retired_d;
   assign cycle_d   = cycle_q + 32'(state_q != S_IDLE && state_q != S_HALT);
   assign retired_d = retired_q + 32'(bus.pc_en);
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         cycle_q   <= '0;
         retired_q <= '0;
      end else begin
         cycle_q   <= cycle_d;
         retired_q <= retired_d;
      end
   assign bus.cycle_cnt   = cycle_q;
   assign bus.retired_cnt = retired_q;
`endif
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed scoreboard bench for stage_sequencer; define SEQ_PERF_CNT_EN for counter checks.
module tb_stage_sequencer;
   localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3,
                          MEMORY = 3'd4, WB = 3'd5, PCU = 3'd6, HALT = 3'd7;
   localparam logic [3:0] AOK = 4'd1, HLT = 4'd2, ADR = 4'd3, INS = 4'd4;
   localparam logic [7:0] IR = 8'h80, DR = 8'h40, DW = 8'h20, FE = 8'h10,
                          EE = 8'h08, ME = 8'h04, WE = 8'h02, PE = 8'h01, NONE = 8'h00;
   logic clk = 1'b0, rst = 1'b0;
   int checks = 0, fails = 0;
   logic [15:0] sb[$];
   stage_sequencer_if bus();
   stage_sequencer #(.DMEM_TIMEOUT(15)) dut (.CLK(clk), .RST(rst), .bus(bus));
   always #5 clk = ~clk;
   // Observation word: stage, stat, halted, then the eight request/enable flags.
   function automatic logic [15:0] ex(input logic [2:0] s, input logic [3:0] st, input logic [7:0] f);
      return {s, st, s == HALT, f};
   endfunction
   function automatic logic [15:0] obs();
      return {bus.stage, bus.stat, bus.halted, bus.imem_req, bus.dmem_req, bus.dmem_write,
              bus.f_en, bus.e_en, bus.m_en, bus.wb_en, bus.pc_en};
   endfunction
   task automatic check(input string tag);
      logic [15:0] e, o;
      checks++;
      if (sb.size() == 0) begin
         fails++;
         $error("FAIL %s scoreboard empty", tag);
         return;
      end
      e = sb.pop_front();
      o = obs();
      assert (o === e) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask
   task automatic cmp32(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask
   task automatic cyc(input logic st, input logic ia, input logic da, input logic [15:0] e, input string tag);
      @(negedge clk);
      bus.start = st;
      bus.imem_ack = ia;
      bus.dmem_ack = da;
      sb.push_back(e);
      #1 check(tag);
   endtask
   task automatic do_reset(input logic [3:0] ic, input logic iv, input logic ie, input logic de);
      @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b0;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      bus.icode = ic;
      bus.instr_valid = iv;
      bus.imem_error = ie;
      bus.dmem_error = de;
      sb.push_back(ex(IDLE, AOK, NONE));
      #1 check("reset");
      rst = 1'b0;
   endtask
   initial begin
      // Non-memory instruction, zero-wait ack: five stages, pc_en in the fifth.
      do_reset(4'h6, 1'b1, 1'b0, 1'b0);
      cyc(1, 0, 0, ex(IDLE, AOK, NONE), "opq_idle");
      cyc(0, 1, 0, ex(FETCH, AOK, IR | FE), "opq_fetch");
      cyc(0, 0, 0, ex(DECODE, AOK, NONE), "opq_decode");
      cyc(0, 0, 0, ex(EXECUTE, AOK, EE), "opq_execute");
      cyc(1, 0, 0, ex(WB, AOK, WE), "opq_wb");
      cyc(0, 0, 0, ex(PCU, AOK, PE), "opq_pcu");
      cyc(0, 0, 0, ex(FETCH, AOK, IR), "opq_refetch_wait");
      // rmmovq with dmem_ack after three wait cycles.
      do_reset(4'h4, 1'b1, 1'b0, 1'b0);
      cyc(1, 0, 0, ex(IDLE, AOK, NONE), "rm_idle");
      cyc(0, 1, 0, ex(FETCH, AOK, IR | FE), "rm_fetch");
      cyc(0, 0, 0, ex(DECODE, AOK, NONE), "rm_decode");
      cyc(0, 0, 0, ex(EXECUTE, AOK, EE), "rm_execute");
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, ex(MEMORY, AOK, DR | DW), "rm_mem_wait");
      cyc(0, 0, 1, ex(MEMORY, AOK, DR | DW | ME), "rm_mem_ack");
      cyc(0, 0, 0, ex(WB, AOK, NONE), "rm_wb");
      cyc(0, 0, 0, ex(PCU, AOK, PE), "rm_pcu");
      cyc(0, 0, 0, ex(FETCH, AOK, IR), "rm_refetch");
      // mrmovq with no dmem_ack: halt after 15 memory cycles, then sticky.
      do_reset(4'h5, 1'b1, 1'b0, 1'b0);
      cyc(1, 0, 0, ex(IDLE, AOK, NONE), "to_idle");
      cyc(0, 1, 0, ex(FETCH, AOK, IR | FE), "to_fetch");
      cyc(0, 0, 0, ex(DECODE, AOK, NONE), "to_decode");
      cyc(0, 0, 0, ex(EXECUTE, AOK, EE), "to_execute");
      for (int i = 0; i < 15; i++) cyc(0, 0, 0, ex(MEMORY, AOK, DR), "to_mem");
      cyc(0, 0, 0, ex(HALT, ADR, NONE), "to_halt");
      cyc(1, 1, 1, ex(HALT, ADR, NONE), "to_halt_sticky");
      cyc(1, 1, 1, ex(HALT, ADR, NONE), "to_halt_sticky2");
      // ret with ack in the limit cycle: ack wins over timeout.
      do_reset(4'h9, 1'b1, 1'b0, 1'b0);
      cyc(1, 0, 0, ex(IDLE, AOK, NONE), "lim_idle");
      cyc(0, 1, 0, ex(FETCH, AOK, IR | FE), "lim_fetch");
      cyc(0, 0, 0, ex(DECODE, AOK, NONE), "lim_decode");
      cyc(0, 0, 0, ex(EXECUTE, AOK, EE), "lim_execute");
      for (int i = 0; i < 14; i++) cyc(0, 0, 0, ex(MEMORY, AOK, DR), "lim_mem");
      cyc(0, 0, 1, ex(MEMORY, AOK, DR | ME), "lim_mem_ack");
      cyc(0, 0, 0, ex(WB, AOK, WE), "lim_wb");
      cyc(0, 0, 0, ex(PCU, AOK, PE), "lim_pcu");
      // Fetch faults and halt instruction.
      do_reset(4'h6, 1'b0, 1'b0, 1'b0);
      cyc(1, 0, 0, ex(IDLE, AOK, NONE), "ins_idle");
      cyc(0, 0, 0, ex(FETCH, AOK, IR), "ins_fetch_wait");
      cyc(0, 1, 0, ex(FETCH, AOK, IR), "ins_fetch_ack");
      cyc(0, 0, 0, ex(HALT, INS, NONE), "ins_halt");
      do_reset(4'h6, 1'b0, 1'b1, 1'b0);
      cyc(1, 0, 0, ex(IDLE, AOK, NONE), "adr_idle");
      cyc(0, 1, 0, ex(FETCH, AOK, IR), "adr_fetch_ack");
      cyc(0, 0, 0, ex(HALT, ADR, NONE), "adr_halt");
      do_reset(4'h0, 1'b1, 1'b0, 1'b0);
      cyc(1, 0, 0, ex(IDLE, AOK, NONE), "hlt_idle");
      cyc(0, 1, 0, ex(FETCH, AOK, IR | FE), "hlt_fetch");
      cyc(0, 0, 0, ex(DECODE, AOK, NONE), "hlt_decode");
      cyc(0, 0, 0, ex(HALT, HLT, NONE), "hlt_halt");
      // call with dmem_error on the ack.
      do_reset(4'h8, 1'b1, 1'b0, 1'b1);
      cyc(1, 0, 0, ex(IDLE, AOK, NONE), "derr_idle");
      cyc(0, 1, 0, ex(FETCH, AOK, IR | FE), "derr_fetch");
      cyc(0, 0, 0, ex(DECODE, AOK, NONE), "derr_decode");
      cyc(0, 0, 0, ex(EXECUTE, AOK, EE), "derr_execute");
      cyc(0, 0, 1, ex(MEMORY, AOK, DR | DW), "derr_mem_ack");
      cyc(0, 0, 0, ex(HALT, ADR, NONE), "derr_halt");
      // Reset mid dmem handshake with acks still pending, then a clean restart.
      do_reset(4'h4, 1'b1, 1'b0, 1'b0);
      cyc(1, 0, 0, ex(IDLE, AOK, NONE), "mid_idle");
      cyc(0, 1, 0, ex(FETCH, AOK, IR | FE), "mid_fetch");
      cyc(0, 0, 0, ex(DECODE, AOK, NONE), "mid_decode");
      cyc(0, 0, 0, ex(EXECUTE, AOK, EE), "mid_execute");
      cyc(0, 0, 0, ex(MEMORY, AOK, DR | DW), "mid_mem");
      @(negedge clk);
      bus.imem_ack = 1'b1;
      bus.dmem_ack = 1'b1;
      rst = 1'b1;
      sb.push_back(ex(IDLE, AOK, NONE));
      #1 check("mid_rst_async");
      rst = 1'b0;
      cyc(0, 1, 1, ex(IDLE, AOK, NONE), "mid_ack_ignored");
      cyc(1, 1, 1, ex(IDLE, AOK, NONE), "mid_restart_idle");
      cyc(0, 1, 0, ex(FETCH, AOK, IR | FE), "mid_refetch");
      cyc(0, 0, 0, ex(DECODE, AOK, NONE), "mid_redecode");
`ifdef SEQ_PERF_CNT_EN
      do_reset(4'h6, 1'b1, 1'b0, 1'b0);
      cmp32("perf_cycle_rst", bus.cycle_cnt, 32'd0);
      cmp32("perf_ret_rst", bus.retired_cnt, 32'd0);
      force dut.retired_q = 32'hFFFF_FFFF;
      cyc(1, 0, 0, ex(IDLE, AOK, NONE), "perf_idle");
      cyc(0, 1, 0, ex(FETCH, AOK, IR | FE), "perf_fetch");
      cyc(0, 0, 0, ex(DECODE, AOK, NONE), "perf_decode");
      cyc(0, 0, 0, ex(EXECUTE, AOK, EE), "perf_execute");
      cyc(0, 0, 0, ex(WB, AOK, WE), "perf_wb");
      cyc(0, 0, 0, ex(PCU, AOK, PE), "perf_pcu");
      release dut.retired_q;
      cyc(0, 0, 0, ex(FETCH, AOK, IR), "perf_refetch");
      cmp32("perf_ret_wrap", bus.retired_cnt, 32'd0);
      cmp32("perf_cycle", bus.cycle_cnt, 32'd5);
`endif
      if (sb.size() != 0) begin
         fails++;
         $error("FAIL scoreboard_drain left=%0d", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
